// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one request at a time, LATENCY wait states,
// byte-enabled stores, misaligned/out-of-range accesses reported as errors.
module dmem_responder #(
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_be_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic            write_q;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;
   logic [3:0]      be_q;
   logic [31:0]     mem [DEPTH];
   logic [AW-1:0]   idx;
   logic            addr_err;

   assign idx      = addr_q[AW+1:2];
   // Upper bits must be zero so out-of-range addresses never alias onto real words.
   assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      case (state)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt         <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  write_q <= req_write_i;
                  addr_q  <= req_addr_i;
                  wdata_q <= req_wdata_i;
                  be_q    <= req_be_i;
                  cnt     <= CW'(LATENCY - 1);
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  rsp_err_o   <= addr_err;
                  rsp_rdata_o <= '0;
                  if (!addr_err) begin
                     if (write_q) begin
                        for (int b = 0; b < 4; b++) begin
                           if (be_q[b]) begin
                              mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                           end
                        end
                     end else begin
                        rsp_rdata_o <= mem[idx];
                     end
                  end
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_rdata_o <= '0;
                  rsp_err_o   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (LATENCY 2, 1, 4) on shared request fields.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req_valid = '0;
   logic [2:0]  req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic [2:0]  rsp_valid;
   logic [2:0]  rsp_ready = 3'b111;
   logic [31:0] rsp_rdata [3];
   logic [2:0]  rsp_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.DEPTH(128), .LATENCY(2)) u_l2 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
      .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
      .rsp_err_o(rsp_err[0]));

   dmem_responder #(.DEPTH(128), .LATENCY(1)) u_l1 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
      .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
      .rsp_err_o(rsp_err[1]));

   dmem_responder #(.DEPTH(128), .LATENCY(4)) u_l4 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
      .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]), .rsp_rdata_o(rsp_rdata[2]),
      .rsp_err_o(rsp_err[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the response handshake.
   task automatic txn(input int k, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input int hold, input string tag);
      int lat;
      logic [31:0] rd0;
      chk({tag, " ready_before"}, 32'(req_ready[k]), 32'd1);
      req_valid[k] = 1'b1;
      req_write    = wr;
      req_addr     = addr;
      req_wdata    = wdata;
      req_be       = be;
      rsp_ready[k] = (hold == 0);
      @(negedge clk);
      acc_cyc      = cyc;
      req_valid[k] = 1'b0;
      // Scramble the request fields; only the accept-edge values may matter.
      req_write    = ~wr;
      req_addr     = 32'h0000_0004;
      req_wdata    = 32'h5555_AAAA;
      req_be       = ~be;
      lat = 0;
      while (!rsp_valid[k] && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " rdata"}, rsp_rdata[k], exp_rdata);
      chk({tag, " err"}, 32'(rsp_err[k]), 32'(exp_err));
      rd0 = rsp_rdata[k];
      for (int h = 0; h < hold; h++) begin
         req_valid[k] = 1'b1;
         req_write    = 1'b1;
         req_addr     = 32'h0000_0010;
         req_wdata    = 32'h0000_0000;
         req_be       = 4'b1111;
         @(negedge clk);
         chk({tag, " hold_valid"}, 32'(rsp_valid[k]), 32'd1);
         chk({tag, " hold_ready"}, 32'(req_ready[k]), 32'd0);
         chk({tag, " hold_rdata"}, rsp_rdata[k], rd0);
      end
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
      @(negedge clk);
      chk({tag, " post_valid"}, 32'(rsp_valid[k]), 32'd0);
      chk({tag, " post_ready"}, 32'(req_ready[k]), 32'd1);
      chk({tag, " post_rdata"}, rsp_rdata[k], 32'd0);
      chk({tag, " post_err"}, 32'(rsp_err[k]), 32'd0);
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [16];

   initial begin
      int a0;
      vecs[0]  = '{1'b1, 32'h10,        32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 32'h10,        32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h10,        32'h11223344, 4'b0101, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 32'h10,        32'h0,        4'b1111, 32'hDE22BE44, 1'b0};
      vecs[4]  = '{1'b1, 32'h10,        32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0};
      vecs[5]  = '{1'b0, 32'h10,        32'h0,        4'b0000, 32'hDE22BE44, 1'b0};
      vecs[6]  = '{1'b0, 32'h12,        32'h0,        4'b0000, 32'h0,        1'b1};
      vecs[7]  = '{1'b1, 32'h200,       32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1};
      vecs[8]  = '{1'b0, 32'h0,         32'h0,        4'b0000, 32'h0,        1'b0};
      vecs[9]  = '{1'b1, 32'h1FC,       32'hA5A55A5A, 4'b1111, 32'h0,        1'b0};
      vecs[10] = '{1'b0, 32'h1FC,       32'h0,        4'b0000, 32'hA5A55A5A, 1'b0};
      vecs[11] = '{1'b1, 32'h8000_0000, 32'h12345678, 4'b1111, 32'h0,        1'b1};
      vecs[12] = '{1'b0, 32'h0,         32'h0,        4'b0000, 32'h0,        1'b0};
      vecs[13] = '{1'b1, 32'h4,         32'h11111111, 4'b1000, 32'h0,        1'b0};
      vecs[14] = '{1'b0, 32'h4,         32'h0,        4'b0000, 32'h11000000, 1'b0};
      vecs[15] = '{1'b1, 32'h7,         32'h99999999, 4'b1111, 32'h0,        1'b1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("reset req_ready", 32'(req_ready[k]), 32'd1);
         chk("reset rsp_valid", 32'(rsp_valid[k]), 32'd0);
         chk("reset rdata", rsp_rdata[k], 32'd0);
         chk("reset err", 32'(rsp_err[k]), 32'd0);
      end

      for (int i = 0; i < 16; i++) begin
         txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].exp_rdata, vecs[i].exp_err, 2, 0, $sformatf("vec%0d", i));
      end

      // Backpressure: response held five cycles while a stray store to 0x10 is offered.
      txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE22BE44, 1'b0, 2, 5, "bp_load");
      txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE22BE44, 1'b0, 2, 0, "bp_after");

      // Reset during the first BUSY cycle drops the store.
      req_valid[0] = 1'b1;
      req_write    = 1'b1;
      req_addr     = 32'h20;
      req_wdata    = 32'hCAFEF00D;
      req_be       = 4'b1111;
      @(negedge clk);
      req_valid[0] = 1'b0;
      rst          = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("midrst req_ready", 32'(req_ready[0]), 32'd1);
      repeat (3) @(negedge clk);
      chk("midrst no_rsp", 32'(rsp_valid[0]), 32'd0);
      txn(0, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h0, 1'b0, 2, 0, "midrst_load20");
      txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 1'b0, 2, 0, "midrst_load10");

      // Other latencies, back-to-back spacing of LATENCY+2 cycles.
      txn(1, 1'b1, 32'h8, 32'h12345678, 4'b1111, 32'h0, 1'b0, 1, 0, "l1_store");
      a0 = acc_cyc;
      txn(1, 1'b0, 32'h8, 32'h0, 4'b0000, 32'h12345678, 1'b0, 1, 0, "l1_load");
      chk("l1 spacing", 32'(acc_cyc - a0), 32'd3);
      txn(2, 1'b1, 32'hC, 32'h87654321, 4'b0011, 32'h0, 1'b0, 4, 0, "l4_store");
      a0 = acc_cyc;
      txn(2, 1'b0, 32'hC, 32'h0, 4'b0000, 32'h00004321, 1'b0, 4, 0, "l4_load");
      chk("l4 spacing", 32'(acc_cyc - a0), 32'd6);
      txn(2, 1'b0, 32'h3FC, 32'h0, 4'b0000, 32'h0, 1'b1, 4, 0, "l4_oor");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory port, i.e. the other end of the load/store interface.
- Accepts one load/store request through a valid/ready handshake and performs the access after a programmable wait-state latency.
- Returns read data or a write acknowledgement through a valid/ready response channel, with byte-enabled writes and address-error reporting.
- Replaces the zero-latency data memory when a stall-capable MEM stage is integrated.

Parameters:
- DEPTH, 128: number of 32-bit storage words; must be a power of two.
- LATENCY, 2: wait states between request accept and response; must be >= 1.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_write_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data.
- req_be_i  in  4  store byte enables; bit n selects byte n (bits [8n+7:8n]).
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  requester takes the response.
- rsp_rdata_o  out  32  load data; 0 for stores and for errors.
- rsp_err_o  out  1  address error for this transaction.

Behaviour:
- Clock is clk_i, reset is rst_i; the only clock; reset is synchronous and active-high.
- Reset, applied at any time including mid-transaction:
  - state = IDLE; req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, counter=0.
  - All DEPTH words cleared to 0.
  - Any in-flight transaction is dropped and its store is not performed.
- FSM states:
  - IDLE: req_ready_o=1. On an edge with req_valid_i=1, latch write, addr, wdata and be; load cnt=LATENCY-1; go to BUSY.
  - BUSY: req_ready_o=0, rsp_valid_o=0. Each edge with cnt!=0: cnt decrements. Edge with cnt==0: perform the access, register rdata and err, go to RESP.
  - RESP: rsp_valid_o=1, req_ready_o=0. On an edge with rsp_ready_i=1, go to IDLE and clear rsp_rdata_o and rsp_err_o to 0.
- Latency:
  - Accept edge E0; rsp_valid_o rises after edge E(LATENCY).
  - Next accept is possible no earlier than the edge after the response handshake.
  - Maximum throughput is one transaction per LATENCY+2 cycles.
- Capture: request inputs are sampled only at the accept edge; later changes are ignored.
- Response stability: rsp_rdata_o and rsp_err_o are held stable while rsp_valid_o=1 and rsp_ready_i=0, for unbounded backpressure.
- Address decode: word index = req_addr_i[log2(DEPTH)+1:2].
- Error (rsp_err_o=1) if either condition holds:
  - req_addr_i[1:0]!=0, or
  - req_addr_i[31:log2(DEPTH)+2]!=0 (out of range; no aliasing).
- On error: no storage change, rsp_rdata_o=0, full latency still applies.
- Load: rsp_rdata_o = the full word; req_be_i is ignored.
- Store: only the enabled bytes are updated. be=0000 is legal, leaves storage unchanged, and gives rsp_err_o=0. rsp_rdata_o=0.
- Simultaneous events:
  - req_valid_i while BUSY/RESP is not accepted; req_ready_o=0 and the requester holds the request.
  - rst_i wins over every handshake on the same edge.
- Counter width: enough bits to hold LATENCY-1 (minimum 1 bit).

Test Plan:
- Reset, then store 0xDEADBEEF be=1111 at 0x10 accepted at E0, rsp_ready_i=1 -> rsp_valid_o high after E2 for one cycle, err=0, rdata=0. Then load 0x10 -> rdata=0xDEADBEEF.
- Following the above, store 0x11223344 be=0101 at 0x10, then load 0x10 -> rdata=0xDE22BE44. Store be=0000 -> err=0, word unchanged.
- Load 0x10 with rsp_ready_i low for 5 cycles -> rsp_valid_o=1 and rdata=0xDE22BE44 stable throughout, req_ready_o=0, a new req_valid_i is ignored. Raise rsp_ready_i -> IDLE next cycle, req_ready_o=1.
- Errors:
  - Load 0x12 -> err=1, rdata=0.
  - Store 0xFFFFFFFF at 0x200 (index 128) -> err=1; load 0x0 -> 0 (no aliasing).
  - Store at 0x1FC (index 127) -> err=0 and the data is stored.
- Reset mid-operation: accept store 0xCAFEF00D at 0x20, assert rst_i in the first BUSY cycle -> next cycle rsp_valid_o=0, req_ready_o=1. Load 0x20 -> 0 (store never performed).
- LATENCY=1 build: accept at E0 -> rsp_valid_o high after E1. LATENCY=4 -> high after E4. Back-to-back requests spaced LATENCY+2 cycles apart.
